// File: rtl/mem_coalesce_issue_pkg.sv
// Shared sizing constants and state encoding for the memory-coalescing issue sequencer.
package mem_coalesce_issue_pkg;

    localparam int SIZE_CORE              = 32;
    localparam int SIZE_CORE_LOG          = 5;
    localparam int SIZE_ADDR              = 32;
    localparam int SIZE_SEGMENT_BYTES_LOG = 6;
    localparam int SIZE_TAG               = SIZE_ADDR - SIZE_SEGMENT_BYTES_LOG;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

endpackage

// File: rtl/mem_coalesce_issue_seg_match.sv
// Combinational segment matcher: finds the lowest pending lane and every pending lane sharing its segment.
module mem_coalesce_issue_seg_match
    import mem_coalesce_issue_pkg::*;
(
    input  logic [SIZE_CORE-1:0]          i_pending,
    input  logic [SIZE_CORE*SIZE_TAG-1:0] i_tags,
    output logic [SIZE_ADDR-1:0]          o_seg_addr,
    output logic [SIZE_CORE-1:0]          o_lane_mask
);

    logic [SIZE_CORE_LOG-1:0] w_first;
    logic                     w_found;
    logic [SIZE_TAG-1:0]      w_first_tag;

    always_comb begin
        w_first = '0;
        w_found = 1'b0;
        for (int i = 0; i < SIZE_CORE; i++) begin
            if (!w_found && i_pending[i]) begin
                w_first = SIZE_CORE_LOG'(i);
                w_found = 1'b1;
            end
        end
    end

    assign w_first_tag = i_tags[w_first*SIZE_TAG +: SIZE_TAG];
    assign o_seg_addr  = {w_first_tag, {SIZE_SEGMENT_BYTES_LOG{1'b0}}};

    always_comb begin
        o_lane_mask = '0;
        for (int i = 0; i < SIZE_CORE; i++) begin
            o_lane_mask[i] = i_pending[i] && (i_tags[i*SIZE_TAG +: SIZE_TAG] == w_first_tag);
        end
    end

endmodule

// File: rtl/mem_coalesce_issue.sv
// Memory-coalescing issue sequencer: one segment-aligned transaction per cycle per accepted warp.
// MEM_COALESCE_STATS_EN adds a per-warp transaction counter output (txn_count).
module mem_coalesce_issue
    import mem_coalesce_issue_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_we,
    input  logic [SIZE_CORE-1:0]           req_mask,
    input  logic [SIZE_CORE*SIZE_ADDR-1:0] req_addr,
    output logic                           mem_valid,
    input  logic                           mem_ready,
    output logic                           mem_we,
    output logic [SIZE_ADDR-1:0]           mem_seg_addr,
    output logic [SIZE_CORE-1:0]           mem_lane_mask,
    output logic                           mem_last,
`ifdef MEM_COALESCE_STATS_EN
    output logic [SIZE_CORE_LOG:0]         txn_count,
`endif
    output logic                           done
);

    state_t                        r_state, w_state_nxt;
    logic [SIZE_CORE-1:0]          r_pending, w_pending_nxt;
    logic [SIZE_CORE*SIZE_TAG-1:0] r_tags, w_req_tags;
    logic                          r_we;
    logic                          r_done, w_done_nxt;
    logic                          w_accept;
    logic                          w_hs;
    logic [SIZE_CORE-1:0]          w_match_mask;
    logic [SIZE_ADDR-1:0]          w_seg_addr;
    logic                          w_unused_offsets;

    // Byte offsets inside a segment never affect merging, so only the segment tags are held.
    always_comb begin
        w_req_tags       = '0;
        w_unused_offsets = 1'b0;
        for (int i = 0; i < SIZE_CORE; i++) begin
            w_req_tags[i*SIZE_TAG +: SIZE_TAG] = req_addr[i*SIZE_ADDR+SIZE_SEGMENT_BYTES_LOG +: SIZE_TAG];
            w_unused_offsets = w_unused_offsets ^ (^req_addr[i*SIZE_ADDR +: SIZE_SEGMENT_BYTES_LOG]);
        end
    end

    mem_coalesce_issue_seg_match u_seg_match (
        .i_pending   (r_pending),
        .i_tags      (r_tags),
        .o_seg_addr  (w_seg_addr),
        .o_lane_mask (w_match_mask)
    );

    assign req_ready     = (r_state == ST_IDLE);
    assign mem_valid     = (r_state == ST_ISSUE);
    assign mem_we        = r_we;
    assign mem_seg_addr  = mem_valid ? w_seg_addr : '0;
    assign mem_lane_mask = w_match_mask;
    assign mem_last      = mem_valid && ((r_pending & ~w_match_mask) == '0);
    assign done          = r_done;
    assign w_accept      = req_ready && req_valid;
    assign w_hs          = mem_valid && mem_ready;

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_done_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_pending_nxt = req_mask;
                    if (req_mask != '0) w_state_nxt = ST_ISSUE;
                    else                w_done_nxt  = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (mem_ready) begin
                    w_pending_nxt = r_pending & ~w_match_mask;
                    if (mem_last) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_tags    <= '0;
            r_we      <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_done    <= w_done_nxt;
            if (w_accept) begin
                r_tags <= w_req_tags;
                r_we   <= req_we;
            end
        end
    end

`ifdef MEM_COALESCE_STATS_EN
    logic [SIZE_CORE_LOG:0] r_txn_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_txn_count <= '0;
        else if (w_accept) r_txn_count <= '0;
        else if (w_hs)     r_txn_count <= r_txn_count + (SIZE_CORE_LOG+1)'(1);
    end

    assign txn_count = r_txn_count;
`endif

endmodule

// File: tb/tb_mem_coalesce_issue.sv
// Directed bench for mem_coalesce_issue with an expected-transaction scoreboard.
module tb_mem_coalesce_issue;
    import mem_coalesce_issue_pkg::*;

    logic                           clk = 1'b0;
    logic                           rst_n;
    logic                           req_valid;
    logic                           req_ready;
    logic                           req_we;
    logic [SIZE_CORE-1:0]           req_mask;
    logic [SIZE_CORE*SIZE_ADDR-1:0] req_addr;
    logic                           mem_valid;
    logic                           mem_ready;
    logic                           mem_we;
    logic [SIZE_ADDR-1:0]           mem_seg_addr;
    logic [SIZE_CORE-1:0]           mem_lane_mask;
    logic                           mem_last;
    logic                           done;
`ifdef MEM_COALESCE_STATS_EN
    logic [SIZE_CORE_LOG:0]         txn_count;
`endif

    typedef struct packed {
        logic [SIZE_ADDR-1:0] seg;
        logic [SIZE_CORE-1:0] mask;
        logic                 last;
        logic                 we;
    } txn_t;

    txn_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [SIZE_CORE*SIZE_ADDR-1:0] addr_v;

    mem_coalesce_issue dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_mask      (req_mask),
        .req_addr      (req_addr),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_we        (mem_we),
        .mem_seg_addr  (mem_seg_addr),
        .mem_lane_mask (mem_lane_mask),
        .mem_last      (mem_last),
`ifdef MEM_COALESCE_STATS_EN
        .txn_count     (txn_count),
`endif
        .done          (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] seg, input logic [31:0] mask, input logic last, input logic we);
        txn_t t;
        t.seg  = seg;
        t.mask = mask;
        t.last = last;
        t.we   = we;
        exp_q.push_back(t);
    endtask

    // Called at a negedge; presents the request for exactly one rising edge.
    task automatic send_req(input logic [31:0] m, input logic [SIZE_CORE*SIZE_ADDR-1:0] a, input logic we);
        check("req_ready_before_req", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_mask  = m;
        req_addr  = a;
        req_we    = we;
        @(negedge clk);
        req_valid = 1'b0;
        req_mask  = '0;
        req_addr  = '0;
        req_we    = 1'b0;
    endtask

    // Compares every offered transaction against the queue head; stalls hold mem_ready low.
    task automatic drain(input string name, input int stall);
        int   budget = 80;
        bit   fin    = 1'b0;
        txn_t e;
        while (!fin && budget > 0) begin
            budget--;
            mem_ready = (stall == 0);
            if (mem_valid) begin
                if (exp_q.size() == 0) begin
                    check({name, "_extra_txn"}, {63'd0, mem_valid}, 64'd0);
                    fin = 1'b1;
                end else begin
                    e = exp_q[0];
                    check({name, "_seg"},  {32'd0, mem_seg_addr},  {32'd0, e.seg});
                    check({name, "_mask"}, {32'd0, mem_lane_mask}, {32'd0, e.mask});
                    check({name, "_last"}, {63'd0, mem_last},      {63'd0, e.last});
                    check({name, "_we"},   {63'd0, mem_we},        {63'd0, e.we});
                    check({name, "_done_low"},  {63'd0, done},      64'd0);
                    check({name, "_busy"},      {63'd0, req_ready}, 64'd0);
                    if (stall > 0) stall--;
                    else begin
                        void'(exp_q.pop_front());
                        if (e.last) fin = 1'b1;
                    end
                end
            end
            @(negedge clk);
        end
        check({name, "_completed"}, {63'd0, fin}, 64'd1);
        check({name, "_done_pulse"}, {63'd0, done},      64'd1);
        check({name, "_idle_valid"}, {63'd0, mem_valid}, 64'd0);
        check({name, "_idle_ready"}, {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        check({name, "_done_one_cycle"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_mask  = '0;
        req_addr  = '0;
        mem_ready = 1'b1;
        #1;
        check("rst_req_ready", {63'd0, req_ready},     64'd1);
        check("rst_mem_valid", {63'd0, mem_valid},     64'd0);
        check("rst_mem_last",  {63'd0, mem_last},      64'd0);
        check("rst_done",      {63'd0, done},          64'd0);
        check("rst_mem_we",    {63'd0, mem_we},        64'd0);
        check("rst_seg",       {32'd0, mem_seg_addr},  64'd0);
        check("rst_mask",      {32'd0, mem_lane_mask}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Unit stride: two segments.
        for (int i = 0; i < SIZE_CORE; i++) addr_v[i*SIZE_ADDR +: SIZE_ADDR] = 32'h1000 + 4*i;
        push(32'h1000, 32'h0000FFFF, 1'b0, 1'b0);
        push(32'h1040, 32'hFFFF0000, 1'b1, 1'b0);
        send_req(32'hFFFFFFFF, addr_v, 1'b0);
        drain("unit", 0);

        // Broadcast, issued as a store.
        for (int i = 0; i < SIZE_CORE; i++) addr_v[i*SIZE_ADDR +: SIZE_ADDR] = 32'h2010;
        push(32'h2000, 32'h0000000F, 1'b1, 1'b1);
        send_req(32'h0000000F, addr_v, 1'b1);
        drain("bcast", 0);

        // Sparse scatter.
        for (int i = 0; i < SIZE_CORE; i++) addr_v[i*SIZE_ADDR +: SIZE_ADDR] = 32'h3000 + 64*i;
        push(32'h3000, 32'h00000001, 1'b0, 1'b0);
        push(32'h3080, 32'h00000004, 1'b1, 1'b0);
        send_req(32'h00000005, addr_v, 1'b0);
        drain("sparse", 0);
`ifdef MEM_COALESCE_STATS_EN
        check("sparse_txn_count", {58'd0, txn_count}, 64'd2);
`endif

        // Interleaved segments: lowest lane picks the segment, not the lowest address.
        for (int i = 0; i < SIZE_CORE; i++)
            addr_v[i*SIZE_ADDR +: SIZE_ADDR] = ((i % 2) == 1) ? (32'h5000 + i) : (32'h5040 + i);
        push(32'h5040, 32'h55555555, 1'b0, 1'b1);
        push(32'h5000, 32'hAAAAAAAA, 1'b1, 1'b1);
        send_req(32'hFFFFFFFF, addr_v, 1'b1);
        drain("interleave", 0);

        // Empty mask: no transaction, done one cycle later.
        send_req(32'h00000000, addr_v, 1'b0);
        check("empty_done",      {63'd0, done},      64'd1);
        check("empty_mem_valid", {63'd0, mem_valid}, 64'd0);
        check("empty_req_ready", {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        check("empty_done_clear", {63'd0, done},      64'd0);
        check("empty_no_valid",   {63'd0, mem_valid}, 64'd0);

        // Backpressure on the first unit-stride transaction.
        for (int i = 0; i < SIZE_CORE; i++) addr_v[i*SIZE_ADDR +: SIZE_ADDR] = 32'h1000 + 4*i;
        push(32'h1000, 32'h0000FFFF, 1'b0, 1'b0);
        push(32'h1040, 32'hFFFF0000, 1'b1, 1'b0);
        send_req(32'hFFFFFFFF, addr_v, 1'b0);
        drain("stall", 3);

        // Reset after the first handshake drops the warp.
        push(32'h1000, 32'h0000FFFF, 1'b0, 1'b0);
        send_req(32'hFFFFFFFF, addr_v, 1'b0);
        mem_ready = 1'b1;
        check("rst_mid_first_seg",  {32'd0, mem_seg_addr},  {32'd0, exp_q[0].seg});
        check("rst_mid_first_mask", {32'd0, mem_lane_mask}, {32'd0, exp_q[0].mask});
        void'(exp_q.pop_front());
        @(negedge clk);
        check("rst_mid_second_mask", {32'd0, mem_lane_mask}, 64'hFFFF0000);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", {63'd0, mem_valid},     64'd0);
        check("rst_mid_mask",  {32'd0, mem_lane_mask}, 64'd0);
        check("rst_mid_ready", {63'd0, req_ready},     64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid_no_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        check("rst_mid_no_done2",  {63'd0, done},      64'd0);
        check("rst_mid_no_valid2", {63'd0, mem_valid}, 64'd0);

        for (int i = 0; i < SIZE_CORE; i++) addr_v[i*SIZE_ADDR +: SIZE_ADDR] = 32'h2010;
        push(32'h2000, 32'h0000000F, 1'b1, 1'b1);
        send_req(32'h0000000F, addr_v, 1'b1);
        drain("post_rst", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
